// File: rtl/keccak_round_sched.sv
// Keccak round scheduler: runs theta..addRC units per round over a
// ping-pong state memory, then pulses done once per permutation.
// Ports:
//   clk, rst    clock, sync active-high reset
//   start       begin a permutation (IDLE only)
//   step_en     one-hot level enable to the active unit
//   step_done   per-unit completion pulses
//   round_idx   current round for addRC
//   rd_bank     bank the active unit reads
//   wr_bank     bank the active unit writes (~rd_bank)
//   busy        high outside IDLE
//   done        one-cycle completion pulse
//   error       sticky fault flag
// Optional macro: ROUND_SCHED_WDOG_EN adds a WAIT-state watchdog.
module keccak_round_sched #(
  parameter int NUM_ROUNDS  = 24,
  parameter int NUM_STEPS   = 5,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [NUM_STEPS-1:0] step_en,
  input  logic [NUM_STEPS-1:0] step_done,
  output logic [4:0]           round_idx,
  output logic                 rd_bank,
  output logic                 wr_bank,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_GAP,
    S_FIN
  } state_t;

  state_t                 state_q;
  logic [SW-1:0]          step_q;
  logic [4:0]             round_q;
  logic                   rd_q;
  logic [NUM_STEPS-1:0]   en_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  logic [NUM_STEPS-1:0]   act_mask;
  logic                   acc;
  logic                   stray;
  logic                   last_step;
  logic                   last_round;
  logic                   wdog_hit;

  assign act_mask   = NUM_STEPS'(1) << step_q;
  assign acc        = |(step_done & act_mask);
  // In IDLE no unit is active, so any pulse is unexpected.
  assign stray      = (state_q == S_IDLE) ? |step_done
                                          : |(step_done & ~act_mask);
  assign last_step  = (step_q == SW'(NUM_STEPS - 1));
  assign last_round = (round_q >= 5'(NUM_ROUNDS - 1));

`ifdef ROUND_SCHED_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] wdog_q;

  // Counts WAIT cycles; zero everywhere else, so RUN entry clears it.
  always_ff @(posedge clk) begin
    if (rst || state_q != S_WAIT) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + CW'(1);
    end
  end

  assign wdog_hit = (state_q == S_WAIT) && !acc &&
                    (wdog_q == CW'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = (WDOG_CYCLES < 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      round_q <= '0;
      rd_q    <= 1'b0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stray) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            step_q  <= '0;
            round_q <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        S_RUN: begin
          en_q    <= act_mask;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (acc) begin
            en_q    <= '0;
            rd_q    <= ~rd_q;
            state_q <= S_GAP;
          end else if (wdog_hit) begin
            en_q    <= '0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
          if (!last_step) begin
            step_q  <= step_q + SW'(1);
            state_q <= S_RUN;
          end else if (!last_round) begin
            step_q  <= '0;
            round_q <= round_q + 5'd1;
            state_q <= S_RUN;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          en_q    <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign step_en   = en_q;
  assign round_idx = round_q;
  assign rd_bank   = rd_q;
  assign wr_bank   = ~rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule
